// File: rtl/line_anim_ctrl_if.sv
// Drawer handshake and framebuffer write port of line_anim_ctrl.
// master = sequencer side, slave = drawer plus framebuffer side.
interface line_anim_ctrl_if #(
  parameter int COORD_W = 11
);
  logic               ld_start;
  logic               ld_done;
  logic               ld_valid;
  logic [COORD_W-1:0] ld_x;
  logic [COORD_W-1:0] ld_y;
  logic [COORD_W-1:0] ld_x0;
  logic [COORD_W-1:0] ld_y0;
  logic [COORD_W-1:0] ld_x1;
  logic [COORD_W-1:0] ld_y1;
  logic [COORD_W-1:0] pix_x;
  logic [COORD_W-1:0] pix_y;
  logic               pix_color;
  logic               pix_write;

  modport master (
    output ld_start,
    output ld_x0,
    output ld_y0,
    output ld_x1,
    output ld_y1,
    output pix_x,
    output pix_y,
    output pix_color,
    output pix_write,
    input  ld_done,
    input  ld_valid,
    input  ld_x,
    input  ld_y
  );

  modport slave (
    input  ld_start,
    input  ld_x0,
    input  ld_y0,
    input  ld_x1,
    input  ld_y1,
    input  pix_x,
    input  pix_y,
    input  pix_color,
    input  pix_write,
    output ld_done,
    output ld_valid,
    output ld_x,
    output ld_y
  );
endinterface

// File: rtl/line_anim_ctrl.sv
// line_anim_ctrl: clear/draw/hold/erase/step sequencer around a line drawer.
// Define LINE_ANIM_TRAIL_EN to skip the erase pass so lines pile up as a trail.
module line_anim_ctrl #(
  parameter int COORD_W     = 11,
  parameter int SCREEN_W    = 640,
  parameter int SCREEN_H    = 480,
  parameter int X0          = 20,
  parameter int Y0          = 20,
  parameter int STEP_X      = 1,
  parameter int STEP_Y      = 1,
  parameter int HOLD_CYCLES = 1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             clear_req,
  line_anim_ctrl_if.master bus,
  output logic             busy,
  output logic [15:0]      frame_count
);

  typedef enum logic [2:0] {
    CLEAR,
    DRAW,
    HOLD,
    ERASE,
    STEP
  } state_t;

  localparam int SW  = COORD_W + 1;
  localparam int HCW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  localparam logic [COORD_W-1:0] X0C  = COORD_W'(X0);
  localparam logic [COORD_W-1:0] Y0C  = COORD_W'(Y0);
  localparam logic [COORD_W-1:0] XMAX = COORD_W'(SCREEN_W - 1);
  localparam logic [COORD_W-1:0] YMAX = COORD_W'(SCREEN_H - 1);

  localparam logic signed [SW-1:0] SX   = SW'(STEP_X);
  localparam logic signed [SW-1:0] SY   = SW'(STEP_Y);
  localparam logic signed [SW-1:0] XLIM = SW'(SCREEN_W - 1);
  localparam logic signed [SW-1:0] YLIM = SW'(SCREEN_H - 1);

  localparam logic [HCW-1:0] HOLD_LAST = HCW'(HOLD_CYCLES - 1);

`ifdef LINE_ANIM_TRAIL_EN
  localparam state_t AFTER_HOLD = STEP;
`else
  localparam state_t AFTER_HOLD = ERASE;
`endif

  state_t             state;
  state_t             state_n;
  logic               live;
  logic [COORD_W-1:0] sweep_x;
  logic [COORD_W-1:0] sweep_y;
  logic [COORD_W-1:0] x1;
  logic [COORD_W-1:0] y1;
  logic               dx_neg;
  logic               dy_neg;
  logic [HCW-1:0]     hold_cnt;
  logic               clear_pending;
  logic               start_q;
  logic [15:0]        frame_cnt;

  logic               sweep_last;
  logic               hold_done;
  logic signed [SW-1:0] nx;
  logic signed [SW-1:0] ny;
  logic [COORD_W-1:0] x1_n;
  logic [COORD_W-1:0] y1_n;
  logic               dx_n;
  logic               dy_n;

  assign sweep_last = (sweep_x == XMAX) && (sweep_y == YMAX);
  assign hold_done  = (hold_cnt == HOLD_LAST);

  always_comb begin
    state_n = state;
    unique case (state)
      CLEAR: if (live && sweep_last) state_n = DRAW;
      DRAW:  if (bus.ld_done) state_n = HOLD;
      HOLD: begin
        if (hold_done && enable) begin
          state_n = clear_pending ? CLEAR : AFTER_HOLD;
        end
      end
      ERASE: if (bus.ld_done) state_n = STEP;
      STEP:  state_n = DRAW;
      default: state_n = CLEAR;
    endcase
  end

  // Endpoint step with bounce; sign bit of the widened sum catches underflow.
  always_comb begin
    nx = dx_neg ? ($signed({1'b0, x1}) - SX)
                : ($signed({1'b0, x1}) + SX);
    ny = dy_neg ? ($signed({1'b0, y1}) - SY)
                : ($signed({1'b0, y1}) + SY);
    x1_n = nx[COORD_W-1:0];
    y1_n = ny[COORD_W-1:0];
    dx_n = dx_neg;
    dy_n = dy_neg;
    if (nx > XLIM) begin
      x1_n = XMAX;
      dx_n = 1'b1;
    end else if (nx[SW-1]) begin
      x1_n = '0;
      dx_n = 1'b0;
    end
    if (ny > YLIM) begin
      y1_n = YMAX;
      dy_n = 1'b1;
    end else if (ny[SW-1]) begin
      y1_n = '0;
      dy_n = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= CLEAR;
      live          <= 1'b0;
      sweep_x       <= '0;
      sweep_y       <= '0;
      x1            <= X0C;
      y1            <= Y0C;
      dx_neg        <= 1'b0;
      dy_neg        <= 1'b0;
      hold_cnt      <= '0;
      clear_pending <= 1'b0;
      start_q       <= 1'b0;
      frame_cnt     <= '0;
    end else begin
      state   <= state_n;
      live    <= 1'b1;
      start_q <= (state_n != state) &&
                 ((state_n == DRAW) || (state_n == ERASE));

      if (clear_req) begin
        clear_pending <= 1'b1;
      end else if ((state == CLEAR) && live && sweep_last) begin
        clear_pending <= 1'b0;
      end

      if ((state == CLEAR) && live) begin
        if (sweep_x == XMAX) begin
          sweep_x <= '0;
          sweep_y <= sweep_last ? '0 : sweep_y + 1'b1;
        end else begin
          sweep_x <= sweep_x + 1'b1;
        end
      end

      // Count saturates so a paused HOLD resumes on the first enabled cycle.
      if (state != HOLD) begin
        hold_cnt <= '0;
      end else if (!hold_done) begin
        hold_cnt <= hold_cnt + 1'b1;
      end

      if ((state == DRAW) && bus.ld_done) begin
        frame_cnt <= frame_cnt + 1'b1;
      end

      if (state == STEP) begin
        x1     <= x1_n;
        y1     <= y1_n;
        dx_neg <= dx_n;
        dy_neg <= dy_n;
      end
    end
  end

  always_comb begin
    bus.pix_x     = bus.ld_x;
    bus.pix_y     = bus.ld_y;
    bus.pix_color = 1'b0;
    bus.pix_write = 1'b0;
    unique case (1'b1)
      (state == CLEAR): begin
        bus.pix_x     = sweep_x;
        bus.pix_y     = sweep_y;
        bus.pix_write = live;
      end
      (state == DRAW): begin
        bus.pix_color = 1'b1;
        bus.pix_write = bus.ld_valid;
      end
      (state == ERASE): begin
        bus.pix_write = bus.ld_valid;
      end
      default: begin
        bus.pix_write = 1'b0;
      end
    endcase
  end

  assign bus.ld_start = start_q;
  assign bus.ld_x0    = X0C;
  assign bus.ld_y0    = Y0C;
  assign bus.ld_x1    = x1;
  assign bus.ld_y1    = y1;
  assign busy         = (state != HOLD);
  assign frame_count  = frame_cnt;

endmodule

// File: tb/tb_line_anim_ctrl.sv
// Bench for line_anim_ctrl: random drawer model plus endpoint/bounce model.
// Small screen so clears are short; bounce exercised on both x edges.
`timescale 1ns/1ps
module tb_line_anim_ctrl;
  localparam int CW  = 11;
  localparam int SW  = 32;
  localparam int SH  = 4;
  localparam int X0  = 20;
  localparam int Y0  = 1;
  localparam int STX = 5;
  localparam int STY = 2;
  localparam int HC  = 4;

  logic        CLOCK_50 = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic        clear_req = 1'b0;
  logic        busy;
  logic [15:0] frame_count;

  line_anim_ctrl_if #(.COORD_W(CW)) bus ();

  line_anim_ctrl #(
    .COORD_W(CW), .SCREEN_W(SW), .SCREEN_H(SH),
    .X0(X0), .Y0(Y0), .STEP_X(STX), .STEP_Y(STY),
    .HOLD_CYCLES(HC)
  ) dut (
    .clk(CLOCK_50),
    .reset(reset),
    .enable(enable),
    .clear_req(clear_req),
    .bus(bus),
    .busy(busy),
    .frame_count(frame_count)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int checks = 0;
  int errors = 0;
  int m_x1, m_y1, m_dx, m_dy, m_frames;

  function automatic int axis(input int p, input int d, input int s,
                              input int mx, output int nd);
    int n;
    n = p + d * s;
    nd = d;
    if (n > mx) begin
      nd = -1;
      return mx;
    end
    if (n < 0) begin
      nd = 1;
      return 0;
    end
    return n;
  endfunction

  task automatic model_reset();
    m_x1 = X0; m_y1 = Y0; m_dx = 1; m_dy = 1; m_frames = 0;
  endtask

  task automatic model_step();
    int nd;
    m_x1 = axis(m_x1, m_dx, STX, SW - 1, nd); m_dx = nd;
    m_y1 = axis(m_y1, m_dy, STY, SH - 1, nd); m_dy = nd;
  endtask

  // Drawer model: waits for ld_start, emits npix pixels with random gaps.
  task automatic drawer(input int npix, input int gmax, input bit color,
                        input int clr_at, output bit started,
                        output int sx1, output int sy1,
                        output int writes, output int bad);
    int gap;
    logic [CW-1:0] vx, vy;
    started = 0; sx1 = -1; sy1 = -1; writes = 0; bad = 0;
    for (int t = 0; t < 400; t++) begin
      if (bus.ld_start) begin
        started = 1;
        break;
      end
      @(negedge CLOCK_50);
    end
    if (!started) return;
    sx1 = int'(bus.ld_x1);
    sy1 = int'(bus.ld_y1);
    for (int p = 0; p < npix; p++) begin
      gap = $urandom_range(gmax, 0);
      for (int g = 0; g < gap; g++) begin
        @(negedge CLOCK_50);
        bus.ld_valid = 1'b0;
        clear_req = 1'b0;
        #1;
        if (bus.pix_write || bus.ld_start || !busy ||
            int'(bus.ld_x1) != sx1 || int'(bus.ld_y1) != sy1) bad++;
      end
      @(negedge CLOCK_50);
      vx = CW'($urandom);
      vy = CW'($urandom);
      bus.ld_valid = 1'b1;
      bus.ld_x = vx;
      bus.ld_y = vy;
      clear_req = (p == clr_at);
      #1;
      if (bus.pix_write !== 1'b1 || bus.pix_x !== vx ||
          bus.pix_y !== vy || bus.pix_color !== color ||
          bus.ld_start || int'(bus.ld_x1) != sx1 ||
          int'(bus.ld_y1) != sy1) bad++;
      else writes++;
    end
    @(negedge CLOCK_50);
    bus.ld_valid = 1'b0;
    clear_req = 1'b0;
    bus.ld_done = 1'b1;
    #1;
    if (bus.pix_write || !busy) bad++;
    @(negedge CLOCK_50);
    bus.ld_done = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    enable = 1'b1;
    bus.ld_valid = 1'b1;
    repeat (3) @(negedge CLOCK_50);
    #1;
    checks++;
    if (bus.ld_start !== 1'b0 || bus.pix_write !== 1'b0) begin
      errors++;
      $display("FAIL reset_strobes: ld_start=%0b pix_write=%0b, expected 0 0",
               bus.ld_start, bus.pix_write);
    end
    checks++;
    if (frame_count !== 16'd0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_count_busy: frame_count=%0d busy=%0b, expected 0 1",
               frame_count, busy);
    end
    checks++;
    if (bus.ld_x1 !== CW'(X0) || bus.ld_y1 !== CW'(Y0) ||
        bus.ld_x0 !== CW'(X0) || bus.ld_y0 !== CW'(Y0)) begin
      errors++;
      $display("FAIL reset_endpoints: x0=%0d y0=%0d x1=%0d y1=%0d, expected %0d %0d %0d %0d",
               bus.ld_x0, bus.ld_y0, bus.ld_x1, bus.ld_y1, X0, Y0, X0, Y0);
    end
    bus.ld_valid = 1'b0;
    @(negedge CLOCK_50);
    reset = 1'b1;
    #1;
  endtask

  task automatic test_clear(input string tag);
    int bad = 0;
    for (int t = 0; t < 20 && !bus.pix_write; t++) @(negedge CLOCK_50);
    checks++;
    if (!bus.pix_write) begin
      errors++;
      $display("FAIL %s_clear_start: pix_write=%0b, expected 1", tag, bus.pix_write);
    end else begin
      for (int i = 0; i < SW * SH; i++) begin
        if (bus.pix_write !== 1'b1 || bus.pix_color !== 1'b0 ||
            bus.pix_x !== CW'(i % SW) || bus.pix_y !== CW'(i / SW) ||
            busy !== 1'b1 || bus.ld_start) bad++;
        bus.ld_done = (i == 5);
        @(negedge CLOCK_50);
      end
      bus.ld_done = 1'b0;
      checks++;
      if (bad !== 0) begin
        errors++;
        $display("FAIL %s_clear_sweep: bad cycles=%0d, expected 0", tag, bad);
      end
      checks++;
      if (bus.ld_start !== 1'b1 || bus.pix_write !== 1'b0) begin
        errors++;
        $display("FAIL %s_clear_to_draw: ld_start=%0b pix_write=%0b, expected 1 0",
                 tag, bus.ld_start, bus.pix_write);
      end
    end
  endtask

  task automatic test_frames(input string tag, input int count, input int nfix);
    bit st;
    int sx, sy, w, bad, hc, hbad, n;
    for (int f = 0; f < count; f++) begin
      n = (nfix > 0) ? nfix : $urandom_range(8, 1);
      drawer(n, (nfix > 0) ? 0 : 2, 1'b1, -1, st, sx, sy, w, bad);
      checks++;
      if (!st || sx !== m_x1 || sy !== m_y1) begin
        errors++;
        $display("FAIL %s_draw_start f%0d: started=%0b x1=%0d y1=%0d, expected 1 %0d %0d",
                 tag, f, st, sx, sy, m_x1, m_y1);
      end
      checks++;
      if (w !== n || bad !== 0) begin
        errors++;
        $display("FAIL %s_draw_pixels f%0d: good=%0d bad=%0d, expected %0d 0",
                 tag, f, w, bad, n);
      end
      m_frames++;
      checks++;
      if (frame_count !== 16'(m_frames)) begin
        errors++;
        $display("FAIL %s_frame_count f%0d: %0d, expected %0d",
                 tag, f, frame_count, m_frames);
      end
      hc = 0; hbad = 0;
      for (int t = 0; t < 50 && !busy; t++) begin
        if (bus.pix_write || bus.ld_start) hbad++;
        hc++;
        @(negedge CLOCK_50);
      end
      checks++;
      if (hc !== HC || hbad !== 0) begin
        errors++;
        $display("FAIL %s_hold f%0d: cycles=%0d bad=%0d, expected %0d 0",
                 tag, f, hc, hbad, HC);
      end
`ifndef LINE_ANIM_TRAIL_EN
      n = $urandom_range(8, 1);
      drawer(n, 2, 1'b0, -1, st, sx, sy, w, bad);
      checks++;
      if (!st || sx !== m_x1 || sy !== m_y1 || w !== n || bad !== 0) begin
        errors++;
        $display("FAIL %s_erase f%0d: started=%0b x1=%0d y1=%0d good=%0d bad=%0d, expected 1 %0d %0d %0d 0",
                 tag, f, st, sx, sy, w, bad, m_x1, m_y1, n);
      end
`endif
      model_step();
    end
  endtask

  task automatic test_clear_req();
    bit st;
    int sx, sy, w, bad, hc;
    drawer(4, 1, 1'b1, 2, st, sx, sy, w, bad);
    checks++;
    if (!st || sx !== m_x1 || sy !== m_y1 || w !== 4 || bad !== 0) begin
      errors++;
      $display("FAIL creq_draw: started=%0b x1=%0d y1=%0d good=%0d bad=%0d, expected 1 %0d %0d 4 0",
               st, sx, sy, w, bad, m_x1, m_y1);
    end
    m_frames++;
    hc = 0;
    for (int t = 0; t < 50 && !busy; t++) begin
      hc++;
      @(negedge CLOCK_50);
    end
    checks++;
    if (hc !== HC || bus.ld_start !== 1'b0 || bus.pix_write !== 1'b1 ||
        bus.pix_color !== 1'b0) begin
      errors++;
      $display("FAIL creq_enter_clear: hold=%0d ld_start=%0b pix_write=%0b color=%0b, expected %0d 0 1 0",
               hc, bus.ld_start, bus.pix_write, bus.pix_color, HC);
    end
    test_clear("creq");
    test_frames("creq_after", 1, 3);
  endtask

  task automatic test_enable_pause();
    bit st;
    int sx, sy, w, bad, pbad;
    pbad = 0;
    drawer(3, 0, 1'b1, -1, st, sx, sy, w, bad);
    checks++;
    if (!st || sx !== m_x1 || sy !== m_y1 || w !== 3 || bad !== 0) begin
      errors++;
      $display("FAIL pause_draw: started=%0b x1=%0d y1=%0d good=%0d bad=%0d, expected 1 %0d %0d 3 0",
               st, sx, sy, w, bad, m_x1, m_y1);
    end
    m_frames++;
    enable = 1'b0;
    for (int t = 0; t < 100; t++) begin
      #1;
      if (busy || bus.ld_start || bus.pix_write) pbad++;
      bus.ld_done = (t == 50);
      @(negedge CLOCK_50);
    end
    bus.ld_done = 1'b0;
    checks++;
    if (pbad !== 0) begin
      errors++;
      $display("FAIL pause_hold: bad cycles=%0d, expected 0", pbad);
    end
    checks++;
    if (frame_count !== 16'(m_frames)) begin
      errors++;
      $display("FAIL pause_frame_count: %0d, expected %0d", frame_count, m_frames);
    end
    enable = 1'b1;
    @(negedge CLOCK_50);
    #1;
    checks++;
`ifndef LINE_ANIM_TRAIL_EN
    if (bus.ld_start !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL pause_resume: ld_start=%0b busy=%0b, expected 1 1",
               bus.ld_start, busy);
    end
`else
    if (bus.ld_start !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL pause_resume: ld_start=%0b busy=%0b, expected 0 1",
               bus.ld_start, busy);
    end
`endif
    model_step();
  endtask

  task automatic test_reset_mid();
    for (int t = 0; t < 300 && !bus.ld_start; t++) @(negedge CLOCK_50);
    repeat (2) begin
      @(negedge CLOCK_50);
      bus.ld_valid = 1'b1;
      bus.ld_x = CW'(3);
      bus.ld_y = CW'(2);
    end
    #1;
    checks++;
    if (bus.pix_write !== 1'b1 || frame_count === 16'd0) begin
      errors++;
      $display("FAIL rmid_pre: pix_write=%0b frame_count=%0d, expected 1 nonzero",
               bus.pix_write, frame_count);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (bus.pix_write !== 1'b0 || bus.ld_start !== 1'b0 ||
        frame_count !== 16'd0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL rmid_outputs: pix_write=%0b ld_start=%0b frame_count=%0d busy=%0b, expected 0 0 0 1",
               bus.pix_write, bus.ld_start, frame_count, busy);
    end
    checks++;
    if (bus.ld_x1 !== CW'(X0) || bus.ld_y1 !== CW'(Y0)) begin
      errors++;
      $display("FAIL rmid_endpoints: x1=%0d y1=%0d, expected %0d %0d",
               bus.ld_x1, bus.ld_y1, X0, Y0);
    end
    @(negedge CLOCK_50);
    @(negedge CLOCK_50);
    bus.ld_valid = 1'b0;
    reset = 1'b1;
    model_reset();
    #1;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.ld_done = 1'b0;
    bus.ld_valid = 1'b0;
    bus.ld_x = '0;
    bus.ld_y = '0;
    model_reset();
    test_reset();
    test_clear("init");
    test_frames("first", 1, 5);
    test_frames("rand", 14, 0);
    test_clear_req();
    test_enable_pause();
    test_reset_mid();
    test_clear("post_reset");
    test_frames("post_reset", 2, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
